// File: rtl/ca_epl_correlator.sv
// ca_epl_correlator
//   Despreads a baseband sample stream against early/prompt/late C/A code
//   replicas and integrate-and-dumps over a programmable number of 1023-chip
//   code epochs. The dump carries the three correlation sums, the number of
//   samples integrated and a sticky saturation flag, strobed by dv_out.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   enable     in   0 = hold in IDLE with accumulators cleared
//   n_epochs   in   code epochs per dump (0 behaves as 1)
//   dv_in      in   sample/code/epoch qualifier
//   sample     in   signed two's-complement baseband sample
//   code_e/p/l in   replica chips, 0 => +1, 1 => -1
//   epoch      in   first sample of a code period (qualified by dv_in)
//   dv_out     out  one-cycle dump strobe
//   e/p/l_sum  out  correlation sums, held until the next dump
//   n_samples  out  dv_in samples integrated in the dump (saturating)
//   sat        out  any accumulator clamped during the dump

// One correlator arm: chip-signed product and saturating accumulator.
module ca_epl_lane #(
    parameter int SAMPLE_W = 4,
    parameter int ACC_W    = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,     // discard partial integration
    input  logic                load,    // restart with this sample's product
    input  logic                add,     // accumulate this sample's product
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                chip,
    output logic [ACC_W-1:0]    acc,
    output logic                ovf      // the add would leave the ACC_W range
);
    localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

    logic [SAMPLE_W:0] smp_x, prod;
    logic [ACC_W-1:0]  prod_x, acc_nxt;
    logic [ACC_W:0]    sum;

    always_comb begin
        // One extra bit so that negating the most negative sample cannot wrap.
        smp_x   = {sample[SAMPLE_W-1], sample};
        prod    = chip ? (~smp_x + 1'b1) : smp_x;
        prod_x  = {{(ACC_W-SAMPLE_W-1){prod[SAMPLE_W]}}, prod};
        sum     = {acc[ACC_W-1], acc} + {prod_x[ACC_W-1], prod_x};
        ovf     = sum[ACC_W] ^ sum[ACC_W-1];
        acc_nxt = ovf ? (sum[ACC_W] ? MINV : MAXV) : sum[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || clr)
            acc <= '0;
        else if (load)
            acc <= prod_x;
        else if (add)
            acc <= acc_nxt;
    end
endmodule

module ca_epl_correlator #(
    parameter int SAMPLE_W = 4,
    parameter int ACC_W    = 24,
    parameter int NEP_W    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NEP_W-1:0]    n_epochs,
    input  logic                dv_in,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                code_e,
    input  logic                code_p,
    input  logic                code_l,
    input  logic                epoch,
    output logic                dv_out,
    output logic [ACC_W-1:0]    e_sum,
    output logic [ACC_W-1:0]    p_sum,
    output logic [ACC_W-1:0]    l_sum,
    output logic [ACC_W-1:0]    n_samples,
    output logic                sat
);
    localparam int NUM_LANES = 3;  // lane 0 = early, 1 = prompt, 2 = late

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                          state, state_nxt;
    logic                            clr, load, add, dump;
    logic [NUM_LANES-1:0]            chips, ovf;
    logic [NUM_LANES-1:0][ACC_W-1:0] acc;
    logic [NEP_W-1:0]                ep_cnt, ep_max;
    logic [ACC_W-1:0]                n_cnt;
    logic                            sticky;

    assign chips  = {code_l, code_p, code_e};
    assign ep_max = (n_epochs == '0) ? NEP_W'(1) : n_epochs;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            ca_epl_lane #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_lane (
                .clk    (clk),
                .reset  (reset),
                .clr    (clr),
                .load   (load),
                .add    (add),
                .sample (sample),
                .chip   (chips[g]),
                .acc    (acc[g]),
                .ovf    (ovf[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        load      = 1'b0;
        add       = 1'b0;
        dump      = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            clr       = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // Only an epoch-aligned sample may open an integration.
                    if (dv_in && epoch) begin
                        state_nxt = ACCUM;
                        load      = 1'b1;
                    end
                end
                ACCUM: begin
                    if (dv_in) begin
                        // >= rather than == so lowering n_epochs mid-dump
                        // below the running count still closes the dump.
                        if (epoch && (ep_cnt >= ep_max)) begin
                            dump = 1'b1;
                            load = 1'b1;
                        end else begin
                            add = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ep_cnt    <= '0;
            n_cnt     <= '0;
            sticky    <= 1'b0;
            dv_out    <= 1'b0;
            e_sum     <= '0;
            p_sum     <= '0;
            l_sum     <= '0;
            n_samples <= '0;
            sat       <= 1'b0;
        end else begin
            dv_out <= dump;
            if (clr) begin
                ep_cnt <= '0;
                n_cnt  <= '0;
                sticky <= 1'b0;
            end else if (load) begin
                ep_cnt <= NEP_W'(1);
                n_cnt  <= ACC_W'(1);
                sticky <= 1'b0;
            end else if (add) begin
                if (!(&n_cnt))
                    n_cnt <= n_cnt + 1'b1;
                if (epoch)
                    ep_cnt <= ep_cnt + 1'b1;
                sticky <= sticky | (|ovf);
            end
            // Dump captures the sums before the current sample is folded in;
            // that sample seeds the next integration through load.
            if (dump) begin
                e_sum     <= acc[0];
                p_sum     <= acc[1];
                l_sum     <= acc[2];
                n_samples <= n_cnt;
                sat       <= sticky;
            end
        end
    end
endmodule

// File: tb/tb_ca_epl_correlator.sv
module tb_ca_epl_correlator;
    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, en12 = 1'b0;
    logic        dv_in = 1'b0, code_e = 1'b0, code_p = 1'b0, code_l = 1'b0, epoch = 1'b0;
    logic [4:0]  n_epochs = 5'd1;
    logic [3:0]  sample = '0;
    logic        dv_out, sat, dv12, sat12;
    logic [23:0] e_sum, p_sum, l_sum, n_samples;
    logic [11:0] e12, p12, l12, n12;

    typedef struct {
        int     e, p, l, n;
        bit     s;
        longint c;
    } exp_t;

    exp_t   q24[$], q12[$];
    int     n_cmp = 0, n_err = 0;
    longint cyc = 0;
    bit     prn[1023];
    int     e_prn, l_prn;

    ca_epl_correlator #(.SAMPLE_W(4), .ACC_W(24), .NEP_W(5)) dut (
        .clk(clk), .reset(reset), .enable(enable), .n_epochs(n_epochs), .dv_in(dv_in),
        .sample(sample), .code_e(code_e), .code_p(code_p), .code_l(code_l), .epoch(epoch),
        .dv_out(dv_out), .e_sum(e_sum), .p_sum(p_sum), .l_sum(l_sum),
        .n_samples(n_samples), .sat(sat));

    // Narrow-accumulator instance for the clamp behaviour; shares all stimulus
    // except enable.
    ca_epl_correlator #(.SAMPLE_W(4), .ACC_W(12), .NEP_W(5)) dut12 (
        .clk(clk), .reset(reset), .enable(en12), .n_epochs(n_epochs), .dv_in(dv_in),
        .sample(sample), .code_e(code_e), .code_p(code_p), .code_l(code_l), .epoch(epoch),
        .dv_out(dv12), .e_sum(e12), .p_sum(p12), .l_sum(l12),
        .n_samples(n12), .sat(sat12));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Pushed before the dumping sample is driven: that sample is taken on the
    // next edge and dv_out is visible right after it.
    task automatic push24(input int e, input int p, input int l, input int n, input bit s);
        exp_t x;
        x.e = e; x.p = p; x.l = l; x.n = n; x.s = s; x.c = cyc + 1;
        q24.push_back(x);
    endtask

    task automatic push12(input int e, input int p, input int l, input int n, input bit s);
        exp_t x;
        x.e = e; x.p = p; x.l = l; x.n = n; x.s = s; x.c = cyc + 1;
        q12.push_back(x);
    endtask

    task automatic drv(input bit dv, input int s, input bit ce, input bit cp, input bit cl, input bit ep);
        dv_in = dv; sample = s[3:0]; code_e = ce; code_p = cp; code_l = cl; epoch = ep;
        @(posedge clk);
        #1;
    endtask

    task automatic per(input int s, input bit ce, input bit cp, input bit cl, input int len, input bit ep0);
        for (int i = 0; i < len; i++)
            drv(1'b1, s, ce, cp, cl, ep0 && (i == 0));
    endtask

    // Monitors: pop an expectation whenever a dump strobe is seen.
    always @(negedge clk) begin
        exp_t x;
        if (dv_out) begin
            if (q24.size() == 0) chk("dut24 unexpected dv_out", 1, 0);
            else begin
                x = q24.pop_front();
                chk("dut24 e_sum", $signed(e_sum), x.e);
                chk("dut24 p_sum", $signed(p_sum), x.p);
                chk("dut24 l_sum", $signed(l_sum), x.l);
                chk("dut24 n_samples", n_samples, x.n);
                chk("dut24 sat", sat, x.s);
                chk("dut24 dv_out cycle", cyc, x.c);
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (dv12) begin
            if (q12.size() == 0) chk("dut12 unexpected dv_out", 1, 0);
            else begin
                x = q12.pop_front();
                chk("dut12 e_sum", $signed(e12), x.e);
                chk("dut12 p_sum", $signed(p12), x.p);
                chk("dut12 l_sum", $signed(l12), x.l);
                chk("dut12 n_samples", n12, x.n);
                chk("dut12 sat", sat12, x.s);
                chk("dut12 dv_out cycle", cyc, x.c);
            end
        end
    end

    initial begin
        bit [10:1] g1, g2;
        bit        fb1, fb2;
        int        si;

        // PRN1: G1 taps 3,10; G2 taps 2,3,6,8,9,10; output G1[10]^G2[2]^G2[6].
        g1 = '1; g2 = '1;
        for (int i = 0; i < 1023; i++) begin
            prn[i] = g1[10] ^ g2[2] ^ g2[6];
            fb1 = g1[3] ^ g1[10];
            fb2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            g1 = {g1[9:1], fb1};
            g2 = {g2[9:1], fb2};
        end
        e_prn = 0; l_prn = 0;
        for (int i = 0; i < 1023; i++) begin
            si = prn[i] ? -1 : 1;
            e_prn += si * (prn[(i + 1) % 1023] ? -1 : 1);
            l_prn += si * (prn[(i + 1022) % 1023] ? -1 : 1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset dv_out", dv_out, 0);
        chk("reset e_sum", e_sum, 0);
        chk("reset p_sum", p_sum, 0);
        chk("reset l_sum", l_sum, 0);
        chk("reset n_samples", n_samples, 0);
        chk("reset sat", sat, 0);
        reset = 1'b0; enable = 1'b1; n_epochs = 5'd1;

        // Constant +3: first epoch opens, second dumps.
        per(3, 0, 0, 0, 1023, 1);
        push24(3069, 3069, 3069, 1023, 0);
        per(3, 0, 0, 0, 1023, 1);

        // PRN1 prompt with matched +/-1 samples, early/late one chip off.
        push24(3069, 3069, 3069, 1023, 0);
        for (int i = 0; i < 1023; i++)
            drv(1'b1, prn[i] ? -1 : 1, prn[(i + 1) % 1023], prn[i], prn[(i + 1022) % 1023], i == 0);

        // n_epochs=4, raised just after the epoch that closes the PRN dump.
        push24(e_prn, 1023, l_prn, 1023, 0);
        per(1, 0, 0, 0, 1, 1);
        n_epochs = 5'd4;
        per(1, 0, 0, 0, 1022, 0);
        repeat (3) per(1, 0, 0, 0, 1023, 1);
        push24(4092, 4092, 4092, 4092, 0);
        per(1, 0, 0, 0, 1, 1);
        n_epochs = 5'd0;
        per(1, 0, 0, 0, 1022, 0);

        // Saturation on the 12-bit instance, positive then negative.
        push24(1023, 1023, 1023, 1023, 0);
        en12 = 1'b1;
        per(7, 0, 0, 0, 1023, 1);
        push24(7161, 7161, 7161, 1023, 0);
        push12(2047, 2047, 2047, 1023, 1);
        per(7, 1, 1, 1, 1023, 1);
        push24(-7161, -7161, -7161, 1023, 0);
        push12(-2048, -2048, -2048, 1023, 1);
        per(1, 0, 0, 0, 1023, 1);
        push24(1023, 1023, 1023, 1023, 0);
        push12(1023, 1023, 1023, 1023, 0);
        per(-8, 1, 0, 1, 1, 1);
        en12 = 1'b0;
        per(-8, 1, 0, 1, 1022, 0);

        // Enable dropped 500 samples into a period: discarded, outputs held.
        push24(8184, -8184, 8184, 1023, 0);
        per(2, 0, 0, 0, 500, 1);
        enable = 1'b0;
        per(2, 0, 0, 0, 523, 0);
        per(2, 0, 0, 0, 200, 1);
        chk("disabled e_sum held", $signed(e_sum), 8184);
        chk("disabled p_sum held", $signed(p_sum), -8184);
        chk("disabled l_sum held", $signed(l_sum), 8184);
        chk("disabled n_samples held", n_samples, 1023);
        chk("disabled sat held", sat, 0);
        enable = 1'b1;
        per(2, 0, 0, 0, 100, 0);
        per(2, 0, 0, 0, 1023, 1);
        push24(2046, 2046, 2046, 1023, 0);
        per(2, 0, 0, 0, 301, 1);

        // Reset mid-period.
        reset = 1'b1;
        drv(1'b1, 2, 0, 0, 0, 0);
        reset = 1'b0;
        chk("midreset dv_out", dv_out, 0);
        chk("midreset e_sum", e_sum, 0);
        chk("midreset p_sum", p_sum, 0);
        chk("midreset l_sum", l_sum, 0);
        chk("midreset n_samples", n_samples, 0);
        chk("midreset sat", sat, 0);
        drv(1'b0, 5, 0, 0, 0, 1);
        chk("post-reset dv_out", dv_out, 0);
        repeat (5) drv(1'b0, 5, 0, 0, 0, 1);

        // Period with dv_in gaps (some carrying epoch) that must not count.
        for (int i = 0; i < 1023; i++) begin
            drv(1'b1, 2, 0, 0, 0, i == 0);
            if (i % 7 == 3) drv(1'b0, 5, 1, 1, 1, i % 2);
        end
        push24(2046, 2046, 2046, 1023, 0);
        drv(1'b1, 2, 0, 0, 0, 1);
        repeat (5) drv(1'b0, 0, 0, 0, 0, 0);

        chk("dut24 dumps outstanding", q24.size(), 0);
        chk("dut12 dumps outstanding", q12.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
